// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide engine.
// Optional build macro honoured by muldiv_unit: MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               qbit_o
);

    logic [WIDTH-1:0] hi_part;
    logic [WIDTH-1:0] lo_part;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             fits;

    always_comb begin
        hi_part = acc_i[2*WIDTH-1:WIDTH];
        lo_part = acc_i[WIDTH-1:0];
        sum     = {1'b0, hi_part} + (lo_part[0] ? {1'b0, opnd_i} : '0);
        // Shifted remainder needs WIDTH+1 bits before the trial subtract.
        diff    = {hi_part, lo_part[WIDTH-1]} - {1'b0, opnd_i};
        fits    = ~diff[WIDTH];
        qbit_o  = 1'b0;
        acc_o   = {sum, lo_part[WIDTH-1:1]};
        if (is_div_i) begin
            qbit_o = fits;
            acc_o  = {(fits ? diff[WIDTH-1:0] : {hi_part[WIDTH-2:0], lo_part[WIDTH-1]}),
                      lo_part[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine producing HI/LO and a divide-by-zero flag.
// Build macro MULDIV_EARLY_OUT_EN enables early multiply termination.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2 * WIDTH;

    muldiv_state_e    state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_res_q, sign_res_d;
    logic             sign_rem_q, sign_rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [ACC_W-1:0] step_acc;
    logic             step_qbit;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             div_zero;
    logic             early_out;
    logic [ACC_W-1:0] fix_acc, prod;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (op_is_div(op_q)),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc),
        .qbit_o   (step_qbit)
    );

    // Operand magnitudes; raw a sits in acc_q low half, raw b in opnd_q during PREP.
    always_comb begin
        mag_a    = acc_q[WIDTH-1:0];
        mag_b    = opnd_q;
        if (op_is_signed(op_q) && acc_q[WIDTH-1]) mag_a = -acc_q[WIDTH-1:0];
        if (op_is_signed(op_q) && opnd_q[WIDTH-1]) mag_b = -opnd_q;
        div_zero = op_is_div(op_q) && (opnd_q == '0);
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0] rem_mask;

    // Remaining multiplier bits occupy acc low bits [cnt_q-1:0] after this step.
    always_comb begin
        rem_mask  = (WIDTH'(1) << cnt_q) - WIDTH'(1);
        early_out = !op_is_div(op_q) && ((step_acc[WIDTH-1:0] & rem_mask) == '0);
        fix_acc   = acc_q >> cnt_q;
    end
`else
    always_comb begin
        early_out = 1'b0;
        fix_acc   = acc_q;
    end
`endif

    always_comb begin
        prod = sign_res_q ? -fix_acc : fix_acc;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_PREP;
            ST_PREP: state_d = div_zero ? ST_DONE : ST_CALC;
            ST_CALC: if ((cnt_q == '0) || early_out) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d       = op_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        sign_res_d = sign_res_q;
        sign_rem_d = sign_rem_q;
        dbz_d      = dbz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d   = op_i;
                    acc_d  = {WIDTH'(0), a_i};
                    opnd_d = b_i;
                    dbz_d  = 1'b0;
                end
            end
            ST_PREP: begin
                sign_res_d = op_is_signed(op_q) && (acc_q[WIDTH-1] ^ opnd_q[WIDTH-1]);
                sign_rem_d = op_is_signed(op_q) && op_is_div(op_q) && acc_q[WIDTH-1];
                if (div_zero) begin
                    dbz_d = 1'b1;
                end else begin
                    cnt_d = CNT_W'(WIDTH - 1);
                    if (op_is_div(op_q)) begin
                        opnd_d = mag_b;
                        acc_d  = {WIDTH'(0), mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {WIDTH'(0), mag_b};
                    end
                end
            end
            ST_CALC: begin
                acc_d = {step_acc[ACC_W-1:1], step_acc[0] | step_qbit};
                if ((cnt_q != '0) && !early_out) cnt_d = cnt_q - CNT_W'(1);
            end
            ST_FIX: begin
                cnt_d = '0;
                if (op_is_div(op_q)) begin
                    lo_d = sign_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = sign_rem_q ? -acc_q[ACC_W-1:WIDTH] : acc_q[ACC_W-1:WIDTH];
                end else begin
                    lo_d = prod[WIDTH-1:0];
                    hi_d = prod[ACC_W-1:WIDTH];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            op_q       <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            sign_res_q <= 1'b0;
            sign_rem_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            op_q       <= op_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            sign_res_q <= sign_res_d;
            sign_rem_q <= sign_rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases plus random operations vs an arithmetic model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op_s = 2'b00;
    logic [W-1:0]  a_s = '0;
    logic [W-1:0]  b_s = '0;
    logic          busy_o, done_o, dbz_o;
    logic [W-1:0]  hi_o, lo_o;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t        expq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;
    logic        prev_done = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk_i         (clk),
        .reset_ni      (rst_n),
        .start_i       (start),
        .op_i          (op_s),
        .a_i           (a_s),
        .b_i           (b_s),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .div_by_zero_o (dbz_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t            e;
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        e.hi = mdl_hi; e.lo = mdl_lo; e.dbz = 1'b0; e.start_cyc = 0; e.lat = 0;
        case (op)
            2'b00: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = ua * ub; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b10: begin
                if (b == 0) e.dbz = 1'b1;
                else begin q = sa / sb; r = sa % sb; e.lo = q[31:0]; e.hi = r[31:0]; end
            end
            default: begin
                if (b == 0) e.dbz = 1'b1;
                else begin p = ua / ub; e.lo = p[31:0]; p = ua % ub; e.hi = p[31:0]; end
            end
        endcase
        return e;
    endfunction

    task automatic push_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(op, a, b);
        e.start_cyc = cyc;
        e.lat = e.dbz ? 1 : W + 2;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) e.lat = -1;
`endif
        mdl_hi = e.hi;
        mdl_lo = e.lo;
        expq.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while (busy_o && n < 200);
        chk("idle_timeout", 64'(busy_o), 64'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin @(negedge clk); n++; end while (!done_o && n < 200);
        chk("done_timeout", 64'(done_o), 64'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op_s = op; a_s = a; b_s = b;
        @(posedge clk); #1;
        start = 1'b0;
        push_exp(op, a, b);
        chk("busy_rise", 64'(busy_o), 64'd1);
        chk("dbz_clear_on_start", 64'(dbz_o), 64'd0);
        wait_idle();
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (done_o) begin
                chk("done_one_cycle", 64'(prev_done), 64'd0);
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
                end else begin
                    e = expq.pop_front();
                    chk("hi", 64'(hi_o), 64'(e.hi));
                    chk("lo", 64'(lo_o), 64'(e.lo));
                    chk("div_by_zero", 64'(dbz_o), 64'(e.dbz));
                    chk("busy_at_done", 64'(busy_o), 64'd1);
                    if (e.lat >= 0) chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
                end
            end
            prev_done = done_o;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        chk("rst_dbz", 64'(dbz_o), 64'd0);
        rst_n = 1'b1;

        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b11, 32'd100, 32'd7);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b01, 32'h8000_0001, 32'd2);
        issue(2'b10, 32'd42, 32'd0);
        issue(2'b00, 32'd3, 32'd4);

        // start held high, operands changed mid-CALC; second op only after done
        @(negedge clk);
        start = 1'b1; op_s = 2'b11; a_s = 32'd100; b_s = 32'd7;
        @(posedge clk); #1;
        push_exp(2'b11, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1 op_s = 2'b00; a_s = 32'd6; b_s = 32'hFFFF_FFFD;
        wait_done();
        @(negedge clk);
        chk("idle_before_restart", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        push_exp(2'b00, 32'd6, 32'hFFFF_FFFD);
        chk("restart_busy", 64'(busy_o), 64'd1);
        wait_idle();

        // reset mid-CALC aborts the operation
        @(negedge clk);
        start = 1'b1; op_s = 2'b00; a_s = 32'd123; b_s = 32'd456;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_done", 64'(done_o), 64'd0);
        chk("abort_hi", 64'(hi_o), 64'd0);
        chk("abort_lo", 64'(lo_o), 64'd0);
        mdl_hi = '0;
        mdl_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(done_o), 64'd0);
        issue(2'b00, 32'd6, 32'd7);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            int          sel;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            else if (sel == 1) rb = '1;
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            issue(rop, ra, rb);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
